// File: rtl/crc12_pkg.sv
// Shared constants, pipe state encoding and the byte-wise CRC-12 step
// (poly 0x80F, init 0xFFF, MSB-first, no reflection, no final XOR).
package crc12_pkg;

    localparam int               CRC12_WIDTH = 12;
    localparam logic [11:0]      CRC12_POLY  = 12'h80F;
    localparam logic [11:0]      CRC12_INIT  = 12'hFFF;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } pipe_state_e;

    function automatic logic [CRC12_WIDTH-1:0] crc12_byte(
        input logic [CRC12_WIDTH-1:0] crc,
        input logic [7:0]             data
    );
        logic [CRC12_WIDTH-1:0] c;
        logic                   fb;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            fb = c[CRC12_WIDTH-1] ^ data[i];
            c  = {c[CRC12_WIDTH-2:0], 1'b0};
            if (fb) begin
                c = c ^ CRC12_POLY;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/crc12_rx_check.sv
// Receive-side CRC-12 checker: strips the 2-byte CRC trailer, forwards payload
// with ready/valid and pulses ok/err per frame. Optional counters: CRC12_RX_STATS_EN.
//
// state | meaning
// EMPTY | delay pipe holds no bytes
// ONE   | b0 valid
// FULL  | b0 and b1 valid; next accepted byte pushes b0 out
module crc12_rx_check
    import crc12_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CRC_WIDTH  = 12
) (
    input  logic                  clk,
    input  logic                  arstn,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  crc_ok,
    output logic                  crc_err,
    output logic                  runt,
    output logic [CRC_WIDTH-1:0]  crc_value
`ifdef CRC12_RX_STATS_EN
    ,
    output logic [15:0]           ok_cnt,
    output logic [15:0]           err_cnt
`endif
);

    pipe_state_e           r_state;
    pipe_state_e           w_state_nxt;
    logic [DATA_WIDTH-1:0] r_b0;
    logic [DATA_WIDTH-1:0] r_b1;
    logic [CRC_WIDTH-1:0]  r_crc_acc;
    logic                  r_m_valid;
    logic [DATA_WIDTH-1:0] r_m_data;
    logic                  r_m_last;
    logic                  r_crc_ok;
    logic                  r_crc_err;
    logic                  r_runt;
    logic [CRC_WIDTH-1:0]  r_crc_value;

    logic                  w_accept;
    logic                  w_emit;
    logic                  w_frame_end;
    logic                  w_runt_end;
    logic                  w_pass;
    logic [CRC_WIDTH-1:0]  w_final;

    // Stall only when a push would have nowhere to go; independent of s_valid.
    assign s_ready = (r_state != FULL) | ~r_m_valid | m_ready;

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_accept) begin
            if (s_last) begin
                w_state_nxt = EMPTY;
            end else begin
                case (r_state)
                    EMPTY:   w_state_nxt = ONE;
                    ONE:     w_state_nxt = FULL;
                    FULL:    w_state_nxt = FULL;
                    default: w_state_nxt = EMPTY;
                endcase
            end
        end
    end

    always_comb begin
        w_accept    = s_valid & s_ready;
        w_emit      = w_accept & (r_state == FULL);
        w_frame_end = w_emit & s_last;
        w_runt_end  = w_accept & s_last & (r_state != FULL);
        w_final     = crc12_byte(r_crc_acc, r_b0);
        w_pass      = (w_final == {r_b1[3:0], s_data}) & (r_b1[7:4] == 4'h0);
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_b0        <= '0;
            r_b1        <= '0;
            r_crc_acc   <= CRC12_INIT;
            r_m_valid   <= 1'b0;
            r_m_data    <= '0;
            r_m_last    <= 1'b0;
            r_crc_ok    <= 1'b0;
            r_crc_err   <= 1'b0;
            r_runt      <= 1'b0;
            r_crc_value <= '0;
        end else begin
            if (w_accept && !s_last) begin
                if (r_state == EMPTY) begin
                    r_b0 <= s_data;
                end else if (r_state == ONE) begin
                    r_b1 <= s_data;
                end else begin
                    r_b0 <= r_b1;
                    r_b1 <= s_data;
                end
            end

            if (w_emit && !s_last) begin
                r_crc_acc <= w_final;
            end else if (w_accept && s_last) begin
                r_crc_acc <= CRC12_INIT;
            end

            // A reload in the same cycle as a handshake replaces the byte with no bubble.
            if (w_emit) begin
                r_m_valid <= 1'b1;
                r_m_data  <= r_b0;
                r_m_last  <= s_last;
            end else if (r_m_valid && m_ready) begin
                r_m_valid <= 1'b0;
            end

            r_crc_ok  <= w_frame_end & w_pass;
            r_crc_err <= (w_frame_end & ~w_pass) | w_runt_end;
            r_runt    <= w_runt_end;
            if (w_frame_end) begin
                r_crc_value <= w_final;
            end
        end
    end

    assign m_valid   = r_m_valid;
    assign m_data    = r_m_data;
    assign m_last    = r_m_last;
    assign crc_ok    = r_crc_ok;
    assign crc_err   = r_crc_err;
    assign runt      = r_runt;
    assign crc_value = r_crc_value;

`ifdef CRC12_RX_STATS_EN
    logic [15:0] r_ok_cnt;
    logic [15:0] r_err_cnt;

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_ok_cnt  <= '0;
            r_err_cnt <= '0;
        end else begin
            if (r_crc_ok && (r_ok_cnt != 16'hFFFF)) begin
                r_ok_cnt <= r_ok_cnt + 16'd1;
            end
            if (r_crc_err && (r_err_cnt != 16'hFFFF)) begin
                r_err_cnt <= r_err_cnt + 16'd1;
            end
        end
    end

    assign ok_cnt  = r_ok_cnt;
    assign err_cnt = r_err_cnt;
`endif

endmodule

// File: doc/crc12_rx_check.md
# crc12_rx_check

Receive-side CRC-12 checker. Takes a byte stream whose frames end with a 2-byte CRC-12 field and strips that field. Forwards the payload downstream with ready/valid backpressure and pulses an ok/error status per frame. Sits at the receive end of the link, opposite the transmit-side CRC-12 generator: polynomial 0x80F, init 0xFFF, MSB-first, no reflection, no final XOR.

## Interface
- DATA_WIDTH, 8, byte width; only 8 is supported.
- CRC_WIDTH, 12, CRC width; only 12 is supported.
- clk  in  1  clock, all logic on the rising edge.
- arstn  in  1  reset, asynchronous, active-low.
- s_valid  in  1  input byte valid.
- s_ready  out  1  input byte accepted when s_valid & s_ready.
- s_data  in  8  input byte.
- s_last  in  1  marks the final byte of a frame (the CRC low byte).
- m_valid  out  1  payload byte valid (registered).
- m_ready  in  1  downstream ready.
- m_data  out  8  payload byte (registered).
- m_last  out  1  final payload byte of a frame.
- crc_ok  out  1  one-cycle pulse: frame CRC matched.
- crc_err  out  1  one-cycle pulse: mismatch, nonzero CRC pad nibble, or runt.
- runt  out  1  qualifies crc_err: frame shorter than 3 bytes.
- crc_value  out  12  computed CRC of the most recent completed frame.

## Operation
- Wire frame format:
  - payload bytes P0..Pn-1 (n ≥ 1), then CRC_HI = {4'h0, crc[11:8]}, then CRC_LO = crc[7:0] with s_last.
- Delay pipe:
  - Holds 2 bytes, b0 (older) and b1 (newer), with fill count 0..2; states EMPTY, ONE, FULL.
  - Needed because the CRC bytes are only identifiable at s_last.
- CRC accumulator:
  - crc_acc resets to 0xFFF.
  - Updated with crc12_byte(crc_acc, b0) only when b0 leaves the pipe to the output register.
- Accepted byte, not last:
  - EMPTY→ONE; ONE→FULL.
  - FULL: b0 is loaded into the output register (m_valid=1, m_last=0), crc_acc is folded, b0←b1, b1←s_data.
- Accepted byte with s_last in FULL:
  - Load b0 into the output register with m_last=1.
  - final = crc12_byte(crc_acc, b0).
  - Pass when final == {b1[3:0], s_data} and b1[7:4] == 0; then crc_ok=1, else crc_err=1.
  - crc_value ← final; crc_acc ← 0xFFF; pipe → EMPTY.
- Accepted byte with s_last in EMPTY or ONE (runt):
  - Nothing is emitted; crc_err=1, runt=1; crc_value is unchanged; pipe → EMPTY; crc_acc ← 0xFFF.
- s_ready = (state != FULL) | ~m_valid | m_ready.
  - Combinational from m_ready only; no combinational path from s_valid.
- Output register:
  - Holds m_data/m_last while m_valid & ~m_ready.
  - Cleared (m_valid=0) on handshake unless reloaded in the same cycle.
- Simultaneous output handshake and reload: allowed; new byte replaces old with no bubble.
- Back-to-back frames: the first byte of frame k+1 may be accepted the cycle after s_last of frame k.

## Timing
- Reset values:
  - s_ready=1, m_valid=0, m_data=0, m_last=0, crc_ok=0, crc_err=0, runt=0, crc_value=0x000.
  - Internally: crc_acc=0xFFF, pipe EMPTY.
- Payload byte Pi appears on m_data one cycle after acceptance of byte i+2, i.e. after CRC_LO for the final payload byte.
- crc_ok/crc_err/runt are high for exactly one cycle, the cycle after s_last is accepted.
  - For non-runt frames this is the same cycle m_valid & m_last first rises.
  - The pulse is not held through m_ready stalls.
- crc_value updates in the same cycle as the status pulse.
- Throughput: one byte per cycle with m_ready held high.
- Reset mid-frame: everything returns to reset values immediately; the partial frame is lost; no status pulse is produced.

## Configuration
- CRC12_RX_STATS_EN defined:
  - Adds ports ok_cnt out 16 and err_cnt out 16, incremented on crc_ok / crc_err respectively.
  - Both saturate at 0xFFFF, reset to 0, and runts count as errors.
- Undefined: the ports and counters are absent; all other behaviour is identical.

## Structure
- Package crc12_pkg holds:
  - CRC12_POLY = 12'h80F, CRC12_INIT = 12'hFFF, CRC12_WIDTH = 12.
  - Pipe state enum {EMPTY, ONE, FULL}.
  - Function crc12_byte(crc, byte), MSB-first, bit step feedback = crc[11]^d, then shift and XOR with POLY when feedback is 1.
- No sub-module; the pipe, output register and FSM live in crc12_rx_check.

## Test plan
- Frame 0x00,0x09,0x06 with m_ready=1 → m_data=0x00 with m_last=1 one cycle after the third byte; crc_ok pulse; crc_value=0x906.
- Frame 0x00,0x09,0x07 → payload 0x00 forwarded with m_last; crc_err=1, runt=0, crc_value=0x906.
- Frame 0x00,0x19,0x06 (nonzero pad nibble) → crc_err pulse, payload still forwarded.
- Runt: 2-byte frame 0xAA,0xBB → no m_valid, crc_err=1 and runt=1 for one cycle; the following 0x00,0x09,0x06 frame → crc_ok.
- Backpressure: m_ready low for 5 cycles mid-frame → s_ready drops once the pipe is FULL and m_valid=1, m_data is held stable, no bytes are lost or duplicated, and the status is still correct.
- Reset asserted after 2 bytes of a frame → all outputs reset; the next 0x00,0x09,0x06 frame → crc_ok. With CRC12_RX_STATS_EN, ok_cnt=1 and err_cnt=0.
